// File: rtl/ssf_reg_ctrl_if.sv
// Cartridge write bus and register/SRAM control outputs of ssf_reg_ctrl.
// The bus is asynchronous to core logic; the controller resynchronizes the strobes internally.
interface ssf_reg_ctrl_if;
    logic [23:1] cart_address;
    logic [15:0] cart_data_in;
    logic        cas0;
    logic        ce_0;
    logic        lwr;
    logic        tme;
    logic        sram_enabled;
    logic        sram_writable;
    logic [41:0] bank_flat;
    logic        sram_we;
    logic        write_ack;
    logic        busy;

    modport master (
        output cart_address, cart_data_in, cas0, ce_0, lwr, tme,
        input  sram_enabled, sram_writable, bank_flat, sram_we, write_ack, busy
    );

    modport slave (
        input  cart_address, cart_data_in, cas0, ce_0, lwr, tme,
        output sram_enabled, sram_writable, bank_flat, sram_we, write_ack, busy
    );
endinterface

// File: rtl/ssf_reg_ctrl.sv
// Mapper register / SRAM write controller: write_ack SYNC_STAGES+3 cycles after lwr falls (register), SYNC_STAGES+2+WE_CYCLES (SRAM).
// No backpressure: lwr falls seen outside IDLE are dropped, and lwr pulses under SYNC_STAGES+1 cycles never write.
module ssf_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int WE_CYCLES   = 3
) (
    input  logic          clk,
    input  logic          vres,
    ssf_reg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        REG_WR,
        SRAM_WR,
        WAIT_REL
    } state_t;

    localparam logic [3:0]      WE_LAST   = 4'(WE_CYCLES - 1);
    localparam logic [7:1][5:0] BANK_RST  = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

    state_t                 state_q, state_d;
    logic [3:0]             we_cnt_q, we_cnt_d;
    logic [SYNC_STAGES-1:0] lwr_sync_q, lwr_sync_d;
    logic [SYNC_STAGES-1:0] tme_sync_q, tme_sync_d;
    logic [SYNC_STAGES-1:0] cas0_sync_q, cas0_sync_d;
    logic [SYNC_STAGES-1:0] ce0_sync_q, ce0_sync_d;
    logic                   lwr_prev_q, lwr_prev_d;
    logic [23:1]            addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic                   tme_cap_q, tme_cap_d;
    logic                   cas0_cap_q, cas0_cap_d;
    logic                   ce0_cap_q, ce0_cap_d;
    logic                   sram_enabled_q, sram_enabled_d;
    logic                   sram_writable_q, sram_writable_d;
    logic [7:1][5:0]        bank_q, bank_d;
    logic                   sram_we_q, sram_we_d;
    logic                   write_ack_q, write_ack_d;
    logic                   busy_q, busy_d;

    logic lwr_s;
    logic detect;
    logic reg_hit;
    logic sram_hit;

    // Address/data bits the decode never looks at.
    logic unused_bits;
    assign unused_bits = ^{addr_q[23:22], addr_q[20:9], data_q[15:6]};

    always_comb begin
        lwr_sync_d  = {lwr_sync_q[SYNC_STAGES-2:0], bus.lwr};
        tme_sync_d  = {tme_sync_q[SYNC_STAGES-2:0], bus.tme};
        cas0_sync_d = {cas0_sync_q[SYNC_STAGES-2:0], bus.cas0};
        ce0_sync_d  = {ce0_sync_q[SYNC_STAGES-2:0], bus.ce_0};
        lwr_s       = lwr_sync_q[SYNC_STAGES-1];
        lwr_prev_d  = lwr_s;
        // Whole chain low: a pulse shorter than the chain never produces an edge.
        detect      = lwr_prev_q && (lwr_sync_q == '0);

        reg_hit  = !tme_cap_q && cas0_cap_q && ce0_cap_q && (addr_q[8:4] == 5'b01111);
        sram_hit = !ce0_cap_q && addr_q[21] && sram_enabled_q && sram_writable_q;

        state_d         = state_q;
        we_cnt_d        = we_cnt_q;
        addr_d          = addr_q;
        data_d          = data_q;
        tme_cap_d       = tme_cap_q;
        cas0_cap_d      = cas0_cap_q;
        ce0_cap_d       = ce0_cap_q;
        sram_enabled_d  = sram_enabled_q;
        sram_writable_d = sram_writable_q;
        bank_d          = bank_q;

        case (state_q)
            IDLE: begin
                if (detect) begin
                    addr_d     = bus.cart_address;
                    data_d     = bus.cart_data_in;
                    tme_cap_d  = tme_sync_q[SYNC_STAGES-1];
                    cas0_cap_d = cas0_sync_q[SYNC_STAGES-1];
                    ce0_cap_d  = ce0_sync_q[SYNC_STAGES-1];
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                // lwr already back high here means the pulse was one cycle too short.
                if (lwr_sync_q[0]) begin
                    state_d = WAIT_REL;
                end else if (reg_hit) begin
                    state_d = REG_WR;
                end else if (sram_hit) begin
                    state_d  = SRAM_WR;
                    we_cnt_d = 4'd0;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            REG_WR: begin
                if (addr_q[3:1] == 3'd0) begin
                    sram_enabled_d  = data_q[0];
                    sram_writable_d = data_q[1];
                end else begin
                    bank_d[addr_q[3:1]] = data_q[5:0];
                end
                state_d = WAIT_REL;
            end
            SRAM_WR: begin
                if (we_cnt_q == WE_LAST) begin
                    state_d = WAIT_REL;
                end else begin
                    we_cnt_d = we_cnt_q + 4'd1;
                end
            end
            WAIT_REL: begin
                if (lwr_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs registered from the next state so they line up with the state they describe.
        sram_we_d   = (state_d != SRAM_WR);
        write_ack_d = (state_d == REG_WR) || ((state_d == SRAM_WR) && (we_cnt_d == WE_LAST));
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            state_q         <= IDLE;
            we_cnt_q        <= 4'd0;
            lwr_sync_q      <= '1;
            tme_sync_q      <= '1;
            cas0_sync_q     <= '1;
            ce0_sync_q      <= '1;
            lwr_prev_q      <= 1'b1;
            addr_q          <= '0;
            data_q          <= '0;
            tme_cap_q       <= 1'b1;
            cas0_cap_q      <= 1'b1;
            ce0_cap_q       <= 1'b1;
            sram_enabled_q  <= 1'b0;
            sram_writable_q <= 1'b0;
            bank_q          <= BANK_RST;
            sram_we_q       <= 1'b1;
            write_ack_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_cnt_q        <= we_cnt_d;
            lwr_sync_q      <= lwr_sync_d;
            tme_sync_q      <= tme_sync_d;
            cas0_sync_q     <= cas0_sync_d;
            ce0_sync_q      <= ce0_sync_d;
            lwr_prev_q      <= lwr_prev_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            tme_cap_q       <= tme_cap_d;
            cas0_cap_q      <= cas0_cap_d;
            ce0_cap_q       <= ce0_cap_d;
            sram_enabled_q  <= sram_enabled_d;
            sram_writable_q <= sram_writable_d;
            bank_q          <= bank_d;
            sram_we_q       <= sram_we_d;
            write_ack_q     <= write_ack_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.sram_enabled  = sram_enabled_q;
    assign bus.sram_writable = sram_writable_q;
    assign bus.bank_flat     = bank_q;
    assign bus.sram_we       = sram_we_q;
    assign bus.write_ack     = write_ack_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_ssf_reg_ctrl.sv
// Directed bench for ssf_reg_ctrl: vector table of cart writes plus hand sequences for WAIT_REL and async reset.
module tb_ssf_reg_ctrl;

    logic clk  = 1'b0;
    logic vres = 1'b0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [41:0] BANK_RST = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
    localparam logic [41:0] BANK_END = {6'h3F, 6'd6, 6'd5, 6'd4, 6'd3, 6'h15, 6'h21};

    ssf_reg_ctrl_if bus ();

    ssf_reg_ctrl #(.SYNC_STAGES(2), .WE_CYCLES(3)) dut (
        .clk  (clk),
        .vres (vres),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ba;
        logic [15:0] dat;
        logic        tme_n;
        logic        cas0;
        logic        ce_n;
        int          low;
        int          exp_ack_cyc;
        int          exp_acks;
        int          exp_we;
        logic        exp_en;
        logic        exp_wr;
        int          bidx;
        logic [5:0]  bval;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // lwr low for low1 cycles, high for gap, low for low2; bus scrambled after the capture cycle.
    task automatic run_write(input logic [23:0] ba, input logic [15:0] dat,
                             input logic tme_n, input logic cs0, input logic ce_n,
                             input int low1, input int gap, input int low2,
                             output int ack_cyc, output int acks, output int we_low,
                             output logic busy_end);
        int ncyc;
        ncyc    = low1 + gap + low2 + 14;
        ack_cyc = 0;
        acks    = 0;
        we_low  = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (c < 4) begin
                bus.cart_address = ba[23:1];
                bus.cart_data_in = dat;
            end else begin
                bus.cart_address = ~ba[23:1];
                bus.cart_data_in = ~dat;
            end
            bus.tme  = tme_n;
            bus.cas0 = cs0;
            bus.ce_0 = ce_n;
            bus.lwr  = !((c <= low1) || ((c > low1 + gap) && (c <= low1 + gap + low2)));
            if (bus.write_ack) begin
                acks++;
                if (ack_cyc == 0) ack_cyc = c;
            end
            if (!bus.sram_we) we_low++;
        end
        busy_end = bus.busy;
        bus.tme  = 1'b1;
        bus.ce_0 = 1'b1;
        bus.cas0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int   ack_cyc, acks, we_low;
        logic busy_end;

        //            addr          data      tme  cas0 ce   low ackc acks we  en    wr    bank val
        vecs[0]  = '{24'hA130F3, 16'h002A, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b0, 1'b0, 1, 6'h2A};
        vecs[1]  = '{24'hA130F5, 16'h0015, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b0, 1'b0, 2, 6'h15};
        vecs[2]  = '{24'hA130FF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b0, 1'b0, 7, 6'h3F};
        vecs[3]  = '{24'hA130E3, 16'h0011, 1'b0, 1'b1, 1'b1, 4, 0, 0, 0, 1'b0, 1'b0, 1, 6'h2A};
        vecs[4]  = '{24'hA130F7, 16'h0009, 1'b1, 1'b1, 1'b1, 4, 0, 0, 0, 1'b0, 1'b0, 3, 6'd3};
        vecs[5]  = '{24'h200000, 16'h1234, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 1'b0, 1'b0, 1, 6'h2A};
        vecs[6]  = '{24'hA130F1, 16'h0001, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b1, 1'b0, 1, 6'h2A};
        vecs[7]  = '{24'h200000, 16'h1234, 1'b1, 1'b1, 1'b0, 10, 0, 0, 0, 1'b1, 1'b0, 1, 6'h2A};
        vecs[8]  = '{24'hA130F1, 16'hFFFE, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b0, 1'b1, 1, 6'h2A};
        vecs[9]  = '{24'hA130F1, 16'h0003, 1'b0, 1'b1, 1'b1, 4, 5, 1, 0, 1'b1, 1'b1, 1, 6'h2A};
        vecs[10] = '{24'h200000, 16'hBEEF, 1'b1, 1'b1, 1'b0, 10, 7, 1, 3, 1'b1, 1'b1, 1, 6'h2A};
        vecs[11] = '{24'h100000, 16'hBEEF, 1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 1'b1, 1'b1, 1, 6'h2A};
        vecs[12] = '{24'h3FFFFE, 16'h5555, 1'b1, 1'b1, 1'b0, 3, 7, 1, 3, 1'b1, 1'b1, 1, 6'h2A};
        vecs[13] = '{24'hA130F3, 16'h0030, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 1'b1, 1'b1, 1, 6'h2A};
        vecs[14] = '{24'hA130F3, 16'h0031, 1'b0, 1'b1, 1'b1, 2, 0, 0, 0, 1'b1, 1'b1, 1, 6'h2A};
        vecs[15] = '{24'hA130F3, 16'h0021, 1'b0, 1'b1, 1'b1, 3, 5, 1, 0, 1'b1, 1'b1, 1, 6'h21};
        vecs[16] = '{24'hA130F9, 16'h000C, 1'b0, 1'b0, 1'b1, 4, 0, 0, 0, 1'b1, 1'b1, 4, 6'd4};

        bus.cart_address = '0;
        bus.cart_data_in = '0;
        bus.lwr  = 1'b1;
        bus.tme  = 1'b1;
        bus.cas0 = 1'b0;
        bus.ce_0 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_held",    64'(bus.sram_we),   64'd1);
        chk("rst_ack_held",   64'(bus.write_ack), 64'd0);
        chk("rst_busy_held",  64'(bus.busy),      64'd0);
        vres = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bank_flat", 64'(bus.bank_flat),     64'(BANK_RST));
        chk("rst_enabled",   64'(bus.sram_enabled),  64'd0);
        chk("rst_writable",  64'(bus.sram_writable), 64'd0);
        chk("rst_we",        64'(bus.sram_we),       64'd1);
        chk("rst_busy",      64'(bus.busy),          64'd0);

        for (int i = 0; i < 17; i++) begin
            run_write(vecs[i].ba, vecs[i].dat, vecs[i].tme_n, vecs[i].cas0, vecs[i].ce_n,
                      vecs[i].low, 0, 0, ack_cyc, acks, we_low, busy_end);
            chk($sformatf("v%0d_ack_cycle", i), 64'(ack_cyc), 64'(vecs[i].exp_ack_cyc));
            chk($sformatf("v%0d_ack_count", i), 64'(acks),    64'(vecs[i].exp_acks));
            chk($sformatf("v%0d_we_cycles", i), 64'(we_low),  64'(vecs[i].exp_we));
            chk($sformatf("v%0d_busy_end", i),  64'(busy_end), 64'd0);
            chk($sformatf("v%0d_enabled", i),   64'(bus.sram_enabled),  64'(vecs[i].exp_en));
            chk($sformatf("v%0d_writable", i),  64'(bus.sram_writable), 64'(vecs[i].exp_wr));
            chk($sformatf("v%0d_bank%0d", i, vecs[i].bidx),
                64'(bus.bank_flat[6*vecs[i].bidx-1 -: 6]), 64'(vecs[i].bval));
        end
        chk("bank_flat_final", 64'(bus.bank_flat), 64'(BANK_END));

        // A second lwr fall that syncs in while the SRAM write is draining must not start another write.
        run_write(24'h200000, 16'h7777, 1'b1, 1'b1, 1'b0, 3, 2, 15, ack_cyc, acks, we_low, busy_end);
        chk("refall_ack_cycle", 64'(ack_cyc),  64'd7);
        chk("refall_ack_count", 64'(acks),     64'd1);
        chk("refall_we_cycles", 64'(we_low),   64'd3);
        chk("refall_busy_end",  64'(busy_end), 64'd0);

        // vres lands in the second SRAM_WR cycle.
        @(posedge clk); #1;
        bus.cart_address = 23'h100000;
        bus.cart_data_in = 16'hAAAA;
        bus.tme  = 1'b1;
        bus.cas0 = 1'b1;
        bus.ce_0 = 1'b0;
        bus.lwr  = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(posedge clk); #1;
        end
        chk("midrst_we_before", 64'(bus.sram_we), 64'd0);
        #2 vres = 1'b0;
        #1;
        chk("midrst_we",        64'(bus.sram_we),       64'd1);
        chk("midrst_ack",       64'(bus.write_ack),     64'd0);
        chk("midrst_busy",      64'(bus.busy),          64'd0);
        chk("midrst_enabled",   64'(bus.sram_enabled),  64'd0);
        chk("midrst_writable",  64'(bus.sram_writable), 64'd0);
        chk("midrst_bank_flat", 64'(bus.bank_flat),     64'(BANK_RST));
        bus.lwr  = 1'b1;
        bus.ce_0 = 1'b1;
        #2 vres = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_we",   64'(bus.sram_we), 64'd1);
        chk("post_rst_busy", 64'(bus.busy),    64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssf_reg_ctrl.md
SSF_REG_CTRL -- requirements
Module: ssf_reg_ctrl

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous cart strobes (legal 2..4).
REQ-002 SHALL provide parameter WE_CYCLES, default 3: SRAM write-enable low width in clk cycles (legal 1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port vres  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cart_address  input  23  cart bus address [23:1], asynchronous.
REQ-006 SHALL have port cart_data_in  input  16  cart bus write data, asynchronous.
REQ-007 SHALL have ports cas0, ce_0, lwr, tme  input  1 each  cart bus strobes, asynchronous, active-low except cas0 (1 = write).
REQ-008 SHALL have port sram_enabled  output  1  SRAM mapped at $200000-$3FFFFF.
REQ-009 SHALL have port sram_writable  output  1  SRAM write permitted.
REQ-010 SHALL have port bank_flat  output  42  banks 1..7, bank i at bits [6i-1:6i-6].
REQ-011 SHALL have port sram_we  output  1  SRAM write enable, active-low.
REQ-012 SHALL have port write_ack  output  1  one-cycle pulse on completion of any accepted write.
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL pass lwr, tme, cas0, ce_0 through SYNC_STAGES flops each; only synchronized copies drive logic.
REQ-015 SHALL detect lwr fall as synced lwr 1 -> 0 between consecutive cycles, only in IDLE.
REQ-016 SHALL, on detect, capture cart_address, cart_data_in and the synced strobes into registers and enter DECODE.
REQ-017 SHALL, in DECODE, select REG_WR if tme=0, cas0=1, ce_0=1, address[8:4]=01111.
REQ-018 SHALL, in DECODE, otherwise select SRAM_WR if ce_0=0, address[21]=1, sram_enabled=1, sram_writable=1.
REQ-019 SHALL, in DECODE, otherwise go to WAIT_REL with no side effect and no write_ack.
REQ-020 SHALL, in REG_WR: address[3:1]=000 -> sram_enabled<=data[0], sram_writable<=data[1]; else bank[address[3:1]]<=data[5:0].
REQ-021 SHALL leave REG_WR after exactly one cycle, pulse write_ack in that cycle, go to WAIT_REL.
REQ-022 SHALL hold sram_we=0 for exactly WE_CYCLES cycles in SRAM_WR via 4-bit counter, pulse write_ack on the last, then go to WAIT_REL.
REQ-023 SHALL stay in WAIT_REL until synced lwr=1, then go to IDLE.
REQ-024 SHALL make register updates visible on outputs the cycle after REG_WR.
REQ-025 SHALL give total latency from lwr pin fall to write_ack of SYNC_STAGES+3 cycles for REG_WR.
REQ-026 SHALL give total latency from lwr pin fall to write_ack of SYNC_STAGES+2+WE_CYCLES cycles for SRAM_WR.
REQ-027 SHALL ignore lwr falls outside IDLE; SRAM_WR SHALL run to full WE_CYCLES even if lwr rises early.
REQ-028 SHALL use captured values only; bus changes after capture SHALL have no effect.
REQ-029 SHALL apply REG_WR changes to sram_enabled/sram_writable from the next decode onward.
REQ-030 SHALL make register writes to address[3:1]=000 with data[15:2]≠0 ignore the upper bits.
REQ-031 SHALL silently drop lwr low pulses shorter than SYNC_STAGES+1 cycles; no partial write.

Reset
REQ-032 SHALL, while vres=0, force sram_enabled=0, sram_writable=0, sram_we=1, write_ack=0, busy=0, FSM=IDLE.
REQ-033 SHALL, while vres=0, set bank[i]=i (6'd1..6'd7) and set synchronizer flops to 1 (strobes inactive).
REQ-034 SHALL, on vres assertion mid-SRAM_WR, drive sram_we high asynchronously without waiting for clk.
REQ-035 SHALL require one clk edge after vres release before the first detect.

Verification
REQ-036 SHALL cover: reset release with lwr high -> bank_flat=6'd7..6'd1 packed, sram_enabled=0, sram_we=1, busy=0.
REQ-037 SHALL cover: write addr $A130F3 (address[3:1]=001), tme=0, data=16'h002A -> bank1=6'h2A, write_ack at SYNC_STAGES+3.
REQ-038 SHALL cover: write $A130F1 data=16'h0003, then ce_0=0, addr $200000, lwr low 10 cycles -> sram_we low exactly 3 cycles, one write_ack.
REQ-039 SHALL cover: SRAM write with sram_writable=0 -> sram_we stays 1, no write_ack, busy returns 0 after lwr rises.
REQ-040 SHALL cover: vres asserted on 2nd SRAM_WR cycle -> sram_we=1 the same instant, all outputs at reset values.
REQ-041 SHALL cover: lwr low 1 cycle (SYNC_STAGES=2) -> no state change; second lwr fall during WAIT_REL -> ignored.
